// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main control unit for a classic multicycle MIPS-style datapath.
// It supports lw, sw, R-type, beq, j and addi. Unknown opcodes are flagged
// in DECODE, and the unit then returns to FETCH.
//
// The state register is the only sequential logic apart from a counter of
// retired instructions. All datapath controls are decoded from the current
// state. The exceptions are the few strobes that also qualify on mem_ready:
//   - the FETCH ir_write and pc_write
//   - retirement in MEM_WR
// The illegal_op strobe also depends on instr_op in DECODE.
//
// Parameters
//   ALU_OP_W    : width of alu_op (>= 2); bits above [1:0] are always zero
//   MEM_WAIT_EN : 1 = memory states wait for mem_ready, 0 = mem_ready ignored
//   CNT_W       : width of retired_cnt
//
// Ports
//   clk, rst         : clock and synchronous active-high reset
//   instr_op[5:0]    : opcode field of the instruction register
//   mem_ready        : memory access completes this cycle
//   pc_write .. alu_src_a : 1-bit datapath controls
//   alu_src_b[1:0]   : 00 regB, 01 const 4, 10 sign-ext imm, 11 shifted imm
//   alu_op           : 00 add, 01 sub, 10 funct-decoded
//   pc_source[1:0]   : 00 ALU result, 01 ALUOut, 10 jump target
//   state[3:0]       : current state encoding (debug / checker visibility)
//   illegal_op       : one-cycle pulse in DECODE for an unknown opcode
//   retired          : one-cycle pulse in the last state of a legal instruction
//   retired_cnt      : count of retired instructions, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int ALU_OP_W    = 2,
    parameter int MEM_WAIT_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          instr_op,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          pc_source,
    output logic [3:0]          state,
    output logic                illegal_op,
    output logic                retired,
    output logic [CNT_W-1:0]    retired_cnt
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           state_q;
    state_t           state_d;
    state_t           out_state;
    logic             ready;
    logic [1:0]       alu_op_base;
    logic [CNT_W-1:0] cnt_q;

    // When waiting is disabled the memory is treated as always ready.
    assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    // A reset cycle presents the FETCH controls whatever the register holds.
    // This also suppresses any retire or illegal strobe in that cycle.
    assign out_state = rst ? S_FETCH : state_q;

    assign state       = state_q;
    assign retired_cnt = cnt_q;

    // ---------------- state register and retired counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retired) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (instr_op)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (instr_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    state_d = ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WR:    state_d = ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            default:     state_d = S_FETCH;  // unused codes 12-15 recover
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op_base   = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        retired       = 1'b0;
        case (out_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = ready;
                pc_write  = ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (instr_op)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                    default:                                       illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retired    = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retired   = ready;
            end
            S_R_EXEC: begin
                alu_src_a   = 1'b1;
                alu_op_base = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retired   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op_base   = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retired       = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retired   = 1'b1;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retired   = 1'b1;
            end
            default: begin
                retired = 1'b0;
            end
        endcase
    end

    // Zero-extend the 2-bit ALU operation into the configured width.
    always_comb begin
        alu_op      = '0;
        alu_op[1:0] = alu_op_base;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Bench for multicycle_control with CNT_W=4 and MEM_WAIT_EN=1. Each test task
// pushes the state sequence and retire strobes it expects into a queue. The
// queue is popped once per cycle against the DUT, and the task also checks
// the controls specific to its scenario.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic       clk;
    logic       rst;
    logic [5:0] instr_op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       illegal_op, retired;
    logic [3:0] retired_cnt;

    int total = 0;
    int bad   = 0;

    // scoreboard: expected state and retire strobe per cycle
    logic [3:0] exp_q[$];
    logic       exp_ret_q[$];
    logic [3:0] exp_cnt;

    multicycle_control #(
        .ALU_OP_W    (2),
        .MEM_WAIT_EN (1),
        .CNT_W       (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_op      (instr_op),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .illegal_op    (illegal_op),
        .retired       (retired),
        .retired_cnt   (retired_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr);
        mem_ready = mr;
        #1;
    endtask

    task automatic push(input logic [3:0] s, input logic r);
        exp_q.push_back(s);
        exp_ret_q.push_back(r);
    endtask

    // pop one expected cycle and compare state / retired
    task automatic sb_compare(input string name);
        logic [3:0] es;
        logic       er;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s sb_empty: got state=%0d, expected an entry", name, state);
        end else begin
            es = exp_q.pop_front();
            er = exp_ret_q.pop_front();
            if (state !== es) begin
                bad++;
                $display("FAIL %s state: got %0d expected %0d", name, state, es);
            end
            total++;
            if (retired !== er) begin
                bad++;
                $display("FAIL %s retired: got %b expected %b (state %0d)", name, retired, er, es);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; instr_op = OP_RTYPE;
        tick(); tick();
        total++; if (state !== 4'd0)      begin bad++; $display("FAIL reset_state: got %0d expected 0", state); end
        total++; if (retired_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d expected 0", retired_cnt); end
        total++; if (mem_read !== 1'b1)    begin bad++; $display("FAIL reset_mem_read: got %b expected 1", mem_read); end
        total++; if (alu_src_b !== 2'b01)  begin bad++; $display("FAIL reset_alu_src_b: got %b expected 01", alu_src_b); end
        total++; if (illegal_op !== 1'b0 || retired !== 1'b0) begin
            bad++; $display("FAIL reset_pulses: got illegal=%b retired=%b expected 0 0", illegal_op, retired);
        end
        rst = 1'b0;
        exp_cnt = 4'd0;
    endtask

    task automatic test_lw();
        instr_op = OP_LW;
        push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd2, 1'b0); push(4'd3, 1'b0); push(4'd4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1);
            if (i == 0) begin
                total++; if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
                    bad++; $display("FAIL lw_fetch: got ir_write=%b pc_write=%b expected 1 1", ir_write, pc_write);
                end
            end
            if (i == 4) begin
                total++; if (reg_write !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin
                    bad++; $display("FAIL lw_wb: got reg_write=%b mem_to_reg=%b reg_dst=%b expected 1 1 0", reg_write, mem_to_reg, reg_dst);
                end
            end
            sb_compare("lw");
            tick();
        end
        exp_cnt = exp_cnt + 4'd1;
        total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL lw_cnt: got %0d expected %0d", retired_cnt, exp_cnt); end
    endtask

    task automatic test_sw_wait();
        logic [6:0] rdy;
        rdy = 7'b1000111;  // bit i = mem_ready in cycle i
        instr_op = OP_SW;
        push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd2, 1'b0);
        push(4'd5, 1'b0); push(4'd5, 1'b0); push(4'd5, 1'b0); push(4'd5, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(rdy[i]);
            if (i >= 3) begin
                total++; if (mem_write !== 1'b1 || i_or_d !== 1'b1) begin
                    bad++; $display("FAIL sw_mem_write: cycle %0d got mem_write=%b i_or_d=%b expected 1 1", i, mem_write, i_or_d);
                end
            end
            sb_compare("sw");
            tick();
        end
        exp_cnt = exp_cnt + 4'd1;
        total++; if (state !== 4'd0 || retired_cnt !== exp_cnt) begin
            bad++; $display("FAIL sw_end: got state=%0d cnt=%0d expected 0 %0d", state, retired_cnt, exp_cnt);
        end
    endtask

    task automatic test_fetch_wait_lw();
        logic [7:0] rdy;
        rdy = 8'b11011100;
        instr_op = OP_LW;
        push(4'd0, 1'b0); push(4'd0, 1'b0); push(4'd0, 1'b0); push(4'd1, 1'b0);
        push(4'd2, 1'b0); push(4'd3, 1'b0); push(4'd3, 1'b0); push(4'd4, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(rdy[i]);
            if (i == 0) begin
                total++; if (ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b1) begin
                    bad++; $display("FAIL fetch_wait: got ir_write=%b pc_write=%b mem_read=%b expected 0 0 1", ir_write, pc_write, mem_read);
                end
            end
            sb_compare("fetch_wait_lw");
            tick();
        end
        exp_cnt = exp_cnt + 4'd1;
        total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL fetch_wait_cnt: got %0d expected %0d", retired_cnt, exp_cnt); end
    endtask

    task automatic test_illegal();
        instr_op = OP_BAD;
        push(4'd0, 1'b0); push(4'd1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1);
            total++; if (illegal_op !== (i == 1)) begin
                bad++; $display("FAIL illegal_pulse: cycle %0d got %b expected %b", i, illegal_op, (i == 1));
            end
            sb_compare("illegal");
            tick();
        end
        total++; if (state !== 4'd0 || retired_cnt !== exp_cnt) begin
            bad++; $display("FAIL illegal_end: got state=%0d cnt=%0d expected 0 %0d", state, retired_cnt, exp_cnt);
        end
    endtask

    task automatic test_alu_paths();
        // R-type: 0,1,6,7
        instr_op = OP_RTYPE;
        push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd6, 1'b0); push(4'd7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1);
            if (i == 2) begin
                total++; if (alu_src_a !== 1'b1 || alu_src_b !== 2'b00 || alu_op !== 2'b10) begin
                    bad++; $display("FAIL r_exec: got src_a=%b src_b=%b alu_op=%b expected 1 00 10", alu_src_a, alu_src_b, alu_op);
                end
            end
            if (i == 3) begin
                total++; if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
                    bad++; $display("FAIL r_wb: got reg_write=%b reg_dst=%b mem_to_reg=%b expected 1 1 0", reg_write, reg_dst, mem_to_reg);
                end
            end
            sb_compare("rtype");
            tick();
        end
        exp_cnt = exp_cnt + 4'd1;
        // addi: 0,1,10,11
        instr_op = OP_ADDI;
        push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd10, 1'b0); push(4'd11, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1);
            if (i == 2) begin
                total++; if (alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_op !== 2'b00) begin
                    bad++; $display("FAIL addi_exec: got src_a=%b src_b=%b alu_op=%b expected 1 10 00", alu_src_a, alu_src_b, alu_op);
                end
            end
            if (i == 3) begin
                total++; if (reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0) begin
                    bad++; $display("FAIL addi_wb: got reg_write=%b reg_dst=%b mem_to_reg=%b expected 1 0 0", reg_write, reg_dst, mem_to_reg);
                end
            end
            sb_compare("addi");
            tick();
        end
        exp_cnt = exp_cnt + 4'd1;
        // beq: 0,1,8
        instr_op = OP_BEQ;
        push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1);
            if (i == 1) begin
                total++; if (alu_src_b !== 2'b11 || alu_op !== 2'b00) begin
                    bad++; $display("FAIL decode_ctl: got src_b=%b alu_op=%b expected 11 00", alu_src_b, alu_op);
                end
            end
            if (i == 2) begin
                total++; if (pc_write_cond !== 1'b1 || pc_source !== 2'b01 || alu_op !== 2'b01 || pc_write !== 1'b0) begin
                    bad++; $display("FAIL beq_ctl: got pwc=%b pc_source=%b alu_op=%b pc_write=%b expected 1 01 01 0", pc_write_cond, pc_source, alu_op, pc_write);
                end
            end
            sb_compare("beq");
            tick();
        end
        exp_cnt = exp_cnt + 4'd1;
        total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL alu_paths_cnt: got %0d expected %0d", retired_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 4'd0;
        instr_op = OP_J;
        for (int k = 0; k < 16; k++) begin
            push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd9, 1'b1);
            for (int i = 0; i < 3; i++) begin
                drive(1'b1);
                if (i == 2 && k == 0) begin
                    total++; if (pc_write !== 1'b1 || pc_source !== 2'b10) begin
                        bad++; $display("FAIL jump_ctl: got pc_write=%b pc_source=%b expected 1 10", pc_write, pc_source);
                    end
                end
                sb_compare("jump_b2b");
                tick();
            end
            exp_cnt = exp_cnt + 4'd1;
            if (k == 14 || k == 15) begin
                total++; if (retired_cnt !== exp_cnt) begin
                    bad++; $display("FAIL jump_cnt: after %0d jumps got %0d expected %0d", k + 1, retired_cnt, exp_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_in_branch();
        instr_op = OP_BEQ;
        push(4'd0, 1'b0); push(4'd1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1);
            sb_compare("rst_branch");
            tick();
        end
        total++; if (state !== 4'd8) begin bad++; $display("FAIL rst_branch_pre: got state=%0d expected 8", state); end
        rst = 1'b1;
        #1;
        total++; if (pc_write_cond !== 1'b0 || retired !== 1'b0 || mem_read !== 1'b1) begin
            bad++; $display("FAIL rst_branch_during: got pwc=%b retired=%b mem_read=%b expected 0 0 1", pc_write_cond, retired, mem_read);
        end
        tick();
        total++; if (state !== 4'd0 || pc_write_cond !== 1'b0 || retired_cnt !== 4'd0) begin
            bad++; $display("FAIL rst_branch_after: got state=%0d pwc=%b cnt=%0d expected 0 0 0", state, pc_write_cond, retired_cnt);
        end
        rst = 1'b0;
        exp_cnt = 4'd0;
    endtask

    task automatic test_reset_mid_wait();
        logic [3:0] rdy;
        rdy = 4'b0111;
        instr_op = OP_LW;
        push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd2, 1'b0); push(4'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(rdy[i]);
            sb_compare("rst_wait");
            if (i < 3) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (state !== 4'd0 || retired_cnt !== 4'd0) begin
            bad++; $display("FAIL rst_wait_after: got state=%0d cnt=%0d expected 0 0", state, retired_cnt);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        instr_op = OP_RTYPE;
        exp_cnt = 4'd0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_fetch_wait_lw();
        test_illegal();
        test_alu_paths();
        test_back_to_back();
        test_reset_in_branch();
        test_reset_mid_wait();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
